press_gen: RTL and testbench
============================

# press_gen

Active-low push-button waveform generator: on request, drives a line low/high in a train of clean "presses" so an edge-detecting receiver on the same line sees exactly one falling edge per press. It lets lock designs and benches synthesise key-press sequences in-fabric instead of needing a physical button. It sits on the transmit side of the button line, ahead of the edge detector and the lock state machine.

## Interface
- PRESS_CYCLES, default 4: cycles press_n is held low per press; must be >= 1.
- GAP_CYCLES, default 3: cycles press_n is held high after each press; must be >= 2, so the receiver's two-stage sampler sees the line high between presses.
- BOUNCE_CYCLES, default 3: length of the bounce prefix per press; used only when PRESS_GEN_BOUNCE_EN is defined.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  request; sampled only while busy=0.
- count  input  4  number of presses (0-15); captured with start.
- press_n  output  1  generated button line, active low; idle high.
- busy  output  1  high while a press train is in progress.
- done  output  1  one-cycle pulse when a train completes.

## Operation
- One clock and one reset: a single clock, clk, and a synchronous, active-low reset, rst_n.
- Reset values: press_n=1, busy=0, done=0, state IDLE, all counters 0.
- FSM states: IDLE, PRESS, GAP, FIN.
- IDLE: press_n=1. If start=1 and count!=0, latch count into the remaining-press counter, load the timer, and go to PRESS. If start=1 and count==0, go to FIN without generating a press.
- PRESS: press_n=0 for PRESS_CYCLES cycles, then go to GAP.
- GAP: press_n=1 for GAP_CYCLES cycles, then decrement the remaining count. If the remaining count is nonzero, go to PRESS; otherwise go to FIN.
- FIN: done=1 and press_n=1 for one cycle. FIN behaves as IDLE for start, so a start in FIN is accepted and a back-to-back train is allowed.
- busy=1 exactly in PRESS and GAP.
- start while busy=1 is ignored, and count is not re-sampled.
- Timer: a down-counter of width $clog2(max(PRESS_CYCLES, GAP_CYCLES, BOUNCE_CYCLES)+1). It never wraps; it reloads on every state entry.
- Remaining-press counter: 4 bits, decremented only in the last GAP cycle. It cannot underflow because count==0 bypasses PRESS.
- Reset mid-train: on the next clock edge press_n=1, busy=0, and no done pulse; the partial press is abandoned.
- press_n is driven directly from a register, so it is glitch-free.

## Timing
- Start accepted at edge E. The first press_n=0 cycle begins at E+1.
- Per press: PRESS_CYCLES low, then GAP_CYCLES high, with no idle cycles between presses.
- Train with N>0 presses: busy is high for N·(PRESS_CYCLES+GAP_CYCLES) cycles starting at E+1, and done pulses in the following cycle.
- count==0: done pulses at E+1; busy and press_n never change.
- Receiver view: a receiver that pulses one cycle per falling edge (two-flop sampler) produces exactly N pulses, each 2 cycles after its press begins.

## Configuration
- PRESS_GEN_BOUNCE_EN defined:
  - Each PRESS is preceded by a BOUNCE state of BOUNCE_CYCLES cycles.
  - In BOUNCE, press_n alternates 0,1,0,... starting at 0.
  - The solid PRESS_CYCLES low period follows.
  - busy covers BOUNCE, and per-press length becomes BOUNCE_CYCLES+PRESS_CYCLES+GAP_CYCLES.
  - Used to exercise debounce logic downstream.
- PRESS_GEN_BOUNCE_EN undefined:
  - No BOUNCE state and no bounce logic is synthesised.
  - BOUNCE_CYCLES is ignored.

## Test plan
All scenarios use defaults PRESS_CYCLES=4, GAP_CYCLES=3, BOUNCE_CYCLES=3, with start accepted at cycle 0.
- Reset: hold rst_n=0 for 3 cycles -> press_n=1, busy=0, done=0 throughout and after release.
- Normal train: start=1 with count=3 -> press_n low cycles 1-4, 8-11 and 15-18, high otherwise; busy high cycles 1-21; done=1 at cycle 22 only. An attached edge detector emits exactly 3 one-cycle pulses.
- Zero count: start=1 with count=0 -> done=1 at cycle 1; press_n stays 1 and busy stays 0.
- Start while busy and back-to-back: start=1, count=5 pulsed at cycle 6 during a count=2 train -> ignored, and exactly 2 presses occur (done at 15). Then start=1, count=1 in the done cycle 15 -> press_n low cycles 16-19, done at 23.
- Reset mid-train: count=4, rst_n=0 sampled at cycle 3 (mid-press) -> press_n=1 and busy=0 from cycle 3; no done pulse ever follows.
- Bounce (PRESS_GEN_BOUNCE_EN defined): count=1 -> press_n = 0,1,0 in cycles 1-3, low in cycles 4-7, high in cycles 8-10; done at cycle 11.

Source files
------------

// File: rtl/press_gen.sv
// press_gen: synthesises clean active-low button presses on press_n, one falling edge per press.
// Define PRESS_GEN_BOUNCE_EN to prefix each press with a 0,1,0,... bounce burst.
module press_gen #(
  parameter int PRESS_CYCLES  = 4,
  parameter int GAP_CYCLES    = 3,
  parameter int BOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] count,
  output logic       press_n,
  output logic       busy,
  output logic       done,
  output logic [2:0] dbg_state
);

  localparam int PG_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
`ifdef PRESS_GEN_BOUNCE_EN
  localparam int MAX_CYC = (BOUNCE_CYCLES > PG_MAX) ? BOUNCE_CYCLES : PG_MAX;
`else
  localparam int MAX_CYC = PG_MAX;
`endif
  localparam int TW = $clog2(MAX_CYC + 1);

`ifdef PRESS_GEN_BOUNCE_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PRESS = 3'd1, S_GAP = 3'd2, S_FIN = 3'd3, S_BOUNCE = 3'd4
  } state_t;
  localparam state_t S_ENTRY = S_BOUNCE;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PRESS = 3'd1, S_GAP = 3'd2, S_FIN = 3'd3
  } state_t;
  localparam state_t S_ENTRY = S_PRESS;
`endif

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0]    rem, rem_nxt;
  logic          press_n_nxt;

  assign dbg_state = state;

  // start is a request taken on any edge where the FSM is in IDLE or FIN (busy=0);
  // while busy=1 both start and count are ignored.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    case (state)
      S_IDLE, S_FIN: begin
        if (start) begin
          if (count != 4'd0) begin
            rem_nxt   = count;
            state_nxt = S_ENTRY;
          end else begin
            state_nxt = S_FIN;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
`ifdef PRESS_GEN_BOUNCE_EN
      S_BOUNCE: if (timer == '0) state_nxt = S_PRESS;
`endif
      S_PRESS:  if (timer == '0) state_nxt = S_GAP;
      S_GAP: begin
        if (timer == '0) begin
          rem_nxt   = rem - 4'd1;
          state_nxt = (rem != 4'd1) ? S_ENTRY : S_FIN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Timer counts down to zero and reloads on every state entry.
  always_comb begin
    timer_nxt = (timer != '0) ? timer - TW'(1) : timer;
    if (state_nxt != state) begin
      case (state_nxt)
        S_PRESS:  timer_nxt = TW'(PRESS_CYCLES - 1);
        S_GAP:    timer_nxt = TW'(GAP_CYCLES - 1);
`ifdef PRESS_GEN_BOUNCE_EN
        S_BOUNCE: timer_nxt = TW'(BOUNCE_CYCLES - 1);
`endif
        default:  timer_nxt = '0;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    press_n_nxt = 1'b1;
    case (state_nxt)
      S_PRESS:  press_n_nxt = 1'b0;
`ifdef PRESS_GEN_BOUNCE_EN
      S_BOUNCE: press_n_nxt = (state == S_BOUNCE) ? ~press_n : 1'b0;
`endif
      default:  press_n_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      rem     <= 4'd0;
      press_n <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      rem     <= rem_nxt;
      press_n <= press_n_nxt;
      busy    <= (state_nxt != S_IDLE) && (state_nxt != S_FIN);
      done    <= (state_nxt == S_FIN);
    end
  end

endmodule

// File: tb/tb_press_gen.sv
// Directed bench for press_gen: cycle-by-cycle checks of press_n/busy/done against hand-computed tables.
module tb_press_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] count;
  logic       press_n;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  press_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .press_n   (press_n),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Receiver model: two-flop sampler, one count per falling edge seen on the line.
  logic s1 = 1'b1;
  logic s2 = 1'b1;
  int   fall_cnt = 0;
  always @(posedge clk) begin
    s1 <= press_n;
    s2 <= s1;
    if (s2 && !s1) fall_cnt <= fall_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cyc(input string name, input int k,
                           input logic ep, input logic eb, input logic ed);
    check($sformatf("%s c%0d press_n", name, k), 32'(press_n), 32'(ep));
    check($sformatf("%s c%0d busy", name, k),    32'(busy),    32'(eb));
    check($sformatf("%s c%0d done", name, k),    32'(done),    32'(ed));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_rng(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  initial begin
    int f0;
    rst_n = 1'b0;
    start = 1'b0;
    count = 4'd0;

    // Reset held for 3 cycles, then released
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_cyc("reset", k, 1'b1, 1'b0, 1'b0);
      check($sformatf("reset c%0d state", k), 32'(dbg_state), 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 4; k <= 5; k++) begin
      tick();
      check_cyc("post_reset", k, 1'b1, 1'b0, 1'b0);
    end

`ifdef PRESS_GEN_BOUNCE_EN
    // Bounce prefix: 0,1,0 then solid low, then gap
    start = 1'b1;
    count = 4'd1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      start = 1'b0;
      check_cyc("bounce", k,
                !((k == 1) || (k == 3) || in_rng(k, 4, 7)),
                in_rng(k, 1, 10), (k == 11));
    end
`else
    // Normal train of 3 presses
    start = 1'b1;
    count = 4'd3;
    f0 = fall_cnt;
    for (int k = 1; k <= 25; k++) begin
      tick();
      start = 1'b0;
      check_cyc("train3", k,
                !(in_rng(k, 1, 4) || in_rng(k, 8, 11) || in_rng(k, 15, 18)),
                in_rng(k, 1, 21), (k == 22));
    end
    check("train3 receiver edges", 32'(fall_cnt - f0), 32'd3);

    // Zero count: done only
    start = 1'b1;
    count = 4'd0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      start = 1'b0;
      check_cyc("zero", k, 1'b1, 1'b0, (k == 1));
    end

    // Start while busy ignored, then back-to-back start in the done cycle
    start = 1'b1;
    count = 4'd2;
    f0 = fall_cnt;
    for (int k = 1; k <= 25; k++) begin
      tick();
      start = (k == 6) || (k == 15);
      if (k == 6)  count = 4'd5;
      if (k == 15) count = 4'd1;
      check_cyc("b2b", k,
                !(in_rng(k, 1, 4) || in_rng(k, 8, 11) || in_rng(k, 16, 19)),
                in_rng(k, 1, 14) || in_rng(k, 16, 22), (k == 15) || (k == 23));
    end
    check("b2b receiver edges", 32'(fall_cnt - f0), 32'd3);

    // Reset mid-press: sampled low at the edge that starts cycle 3
    start = 1'b1;
    count = 4'd4;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start = 1'b0;
      rst_n = !((k == 2) || (k == 3));
      check_cyc("midrst", k, !in_rng(k, 1, 2), in_rng(k, 1, 2), 1'b0);
    end
    check("midrst state", 32'(dbg_state), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
